// File: rtl/uart_com_buffered.sv
// Buffered UART transceiver: TX/RX serialisers with valid/ready FIFOs,
// per-word frame/parity error flags and a sticky RX overrun flag.
module uart_com_buffered #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned TX_DEPTH     = 16,
  parameter int unsigned RX_DEPTH     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         uart_rx,
  output logic                         uart_tx,
  input  logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [DATA_BITS-1:0]         rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic                         rx_frame_err,
  output logic                         rx_parity_err,
  output logic                         rx_overrun,
  input  logic                         err_clr,
  output logic [$clog2(TX_DEPTH):0]    tx_level,
  output logic [$clog2(RX_DEPTH):0]    rx_level,
  output logic                         tx_busy
);

  localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned TAW = $clog2(TX_DEPTH);
  localparam int unsigned RAW = $clog2(RX_DEPTH);
  localparam int unsigned RW  = DATA_BITS + 2;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TAW-1:0]       tx_wr_ptr, tx_rd_ptr;
  logic                 tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_ready = (tx_level != (TAW+1)'(TX_DEPTH));
  assign tx_push  = tx_valid && tx_ready;
  assign tx_head  = tx_mem[tx_rd_ptr];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_push && !tx_pop)      tx_level <= tx_level + 1'b1;
      else if (!tx_push && tx_pop) tx_level <= tx_level - 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  tx_state_t            tx_state, tx_state_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [3:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_par, tx_par_n;
  logic                 tx_line, tx_tick, tx_load;

  always_comb begin
    tx_state_n = tx_state;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    tx_line    = 1'b1;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    tx_tick    = (tx_cnt == BIT_LAST);
    tx_cnt_n   = (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
    case (tx_state)
      TX_IDLE: tx_load = (tx_level != '0);
      TX_START: begin
        tx_line = 1'b0;
        if (tx_tick) begin
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_line = tx_sh[0];
        if (tx_tick) begin
          tx_sh_n = tx_sh >> 1;
          if (tx_bit == DATA_LAST) begin
            tx_bit_n   = '0;
            tx_state_n = (PARITY != 0) ? TX_PAR : TX_STOP;
          end else begin
            tx_bit_n = tx_bit + 1'b1;
          end
        end
      end
      TX_PAR: begin
        tx_line = tx_par;
        if (tx_tick) begin
          tx_bit_n   = '0;
          tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          if (tx_bit == STOP_LAST) begin
            // Chain straight into the next START so queued words go out gap-free
            tx_load    = (tx_level != '0);
            tx_state_n = TX_IDLE;
          end else begin
            tx_bit_n = tx_bit + 1'b1;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_sh_n    = tx_head;
      tx_par_n   = (PARITY == 1) ? ~(^tx_head) : ^tx_head;
      tx_cnt_n   = '0;
      tx_state_n = TX_START;
    end
  end

  // uart_tx is registered, adding one cycle of push-to-line latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      uart_tx  <= tx_line;
    end
  end

  assign tx_busy = (tx_state != TX_IDLE);

  // ---------------- RX synchroniser ----------------
  logic rx_meta, rx_s, rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // ---------------- RX FSM ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  rx_state_t            rx_state, rx_state_n;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [3:0]           rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_perr, rx_perr_n;
  logic                 rx_tick, rx_req;

  always_comb begin
    rx_state_n = rx_state;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_perr_n  = rx_perr;
    rx_req     = 1'b0;
    rx_tick    = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);
    rx_cnt_n   = (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
    case (rx_state)
      // Edge-triggered arming: a line held low after a bad stop bit cannot restart RX
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_perr_n  = 1'b0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_sh_n = {rx_s, rx_sh[DATA_BITS-1:1]};
          if (rx_bit == DATA_LAST) rx_state_n = (PARITY != 0) ? RX_PAR : RX_STOP;
          else                     rx_bit_n   = rx_bit + 1'b1;
        end
      end
      RX_PAR: begin
        if (rx_tick) begin
          rx_perr_n  = (PARITY == 1) ? ~(^rx_sh ^ rx_s) : (^rx_sh ^ rx_s);
          rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_req     = 1'b1;
          rx_state_n = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_perr  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_perr  <= rx_perr_n;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [RW-1:0]  rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic           rx_full, rx_push, rx_pop;
  logic [RW-1:0]  rx_head;

  assign rx_full  = (rx_level == (RAW+1)'(RX_DEPTH));
  assign rx_valid = (rx_level != '0);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_push  = rx_req && (!rx_full || rx_pop);
  assign rx_head  = rx_mem[rx_rd_ptr];

  assign rx_data       = rx_valid ? rx_head[DATA_BITS-1:0] : '0;
  assign rx_frame_err  = rx_valid && rx_head[DATA_BITS];
  assign rx_parity_err = rx_valid && rx_head[DATA_BITS+1];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= {rx_perr, ~rx_s, rx_sh};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_level   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_push && !rx_pop)      rx_level <= rx_level + 1'b1;
      else if (!rx_push && rx_pop) rx_level <= rx_level - 1'b1;
      if (rx_req && rx_full && !rx_pop) rx_overrun <= 1'b1;
      else if (err_clr)                 rx_overrun <= 1'b0;
    end
  end

endmodule
